gpio_scan_sequencer: RTL and testbench

On-chip sequencer that drives the OpenRAM test chip's GPIO scan interface from a parallel command/response handshake. It serially shifts a full instruction word into the test chip's instruction register and opens a chip-select access window. It then pulses the SRAM-capture load and shifts the captured register back out, returning it as a parallel response. It sits directly upstream of `openram_testchip`, driving `gpio_in`, `gpio_scan`, `gpio_sram_load` and `global_csb`, and directly downstream of it, consuming `gpio_out`.

---
 rtl/gpio_scan_pkg.sv | 20 ++
 rtl/gpio_scan_sequencer_if.sv | 26 ++
 rtl/gpio_scan_sequencer_shifter.sv | 33 +++
 rtl/gpio_scan_sequencer.sv | 158 +++++++++++++++
 tb/tb_gpio_scan_sequencer.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/gpio_scan_pkg.sv
// Shared types and helpers for the GPIO scan sequencer.
// State enum, default register width and counter sizing.
package gpio_scan_pkg;

   localparam int REG_WIDTH_DEF = 112;

   typedef enum logic [2:0] {
      IDLE,
      SHIFT_IN,
      ACCESS,
      LOAD,
      SHIFT_OUT,
      RESP
   } state_e;

   function automatic int cnt_width(input int w);
      return $clog2(w + 1);
   endfunction

endpackage

// File: rtl/gpio_scan_sequencer_if.sv
// Command/response handshake bundle of the GPIO scan sequencer.
// master = requester side, slave = sequencer side.
interface gpio_scan_sequencer_if
   import gpio_scan_pkg::*;
#(
   parameter int REG_WIDTH = REG_WIDTH_DEF
);

   logic                 cmd_valid;
   logic                 cmd_ready;
   logic [REG_WIDTH-1:0] cmd_data;
   logic                 rsp_valid;
   logic                 rsp_ready;
   logic [REG_WIDTH-1:0] rsp_data;

   modport master (
      output cmd_valid, cmd_data, rsp_ready,
      input  cmd_ready, rsp_valid, rsp_data
   );

   modport slave (
      input  cmd_valid, cmd_data, rsp_ready,
      output cmd_ready, rsp_valid, rsp_data
   );

endinterface

// File: rtl/gpio_scan_sequencer_shifter.sv
// Parallel-load shift register: MSB serial out, LSB serial in.
// Load takes priority over shift.
module scan_shifter
   import gpio_scan_pkg::*;
#(
   parameter int REG_WIDTH = REG_WIDTH_DEF
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 load_i,
   input  logic                 shift_i,
   input  logic [REG_WIDTH-1:0] d_i,
   input  logic                 sin_i,
   output logic [REG_WIDTH-1:0] q_o,
   output logic                 sout_o
);

   logic [REG_WIDTH-1:0] sh_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sh_q <= '0;
      end else if (load_i) begin
         sh_q <= d_i;
      end else if (shift_i) begin
         sh_q <= {sh_q[REG_WIDTH-2:0], sin_i};
      end
   end

   assign q_o    = sh_q;
   assign sout_o = sh_q[REG_WIDTH-1];

endmodule

// File: rtl/gpio_scan_sequencer.sv
// GPIO scan sequencer for the OpenRAM test chip scan chain.
// Define GPIO_SCAN_READBACK_EN for the LOAD/SHIFT_OUT readback.
module gpio_scan_sequencer
   import gpio_scan_pkg::*;
#(
   parameter int REG_WIDTH     = REG_WIDTH_DEF,
   parameter int ACCESS_CYCLES = 2
) (
   input  logic                 clk,
   input  logic                 resetn,
   gpio_scan_sequencer_if.slave bus,
   output logic                 busy,
   output logic                 gpio_scan,
   output logic                 gpio_in,
   output logic                 gpio_sram_load,
   output logic                 global_csb,
   input  logic                 gpio_out
);

   localparam int MAXC =
      (REG_WIDTH > ACCESS_CYCLES) ? REG_WIDTH : ACCESS_CYCLES;
   localparam int CW = cnt_width(MAXC);
   localparam logic [CW-1:0] W_LAST = CW'(REG_WIDTH - 1);
   localparam logic [CW-1:0] A_LAST = CW'(ACCESS_CYCLES - 1);

   state_e          state_q;
   logic [CW-1:0]   cnt_q;
   logic            cmd_ready_q;
   logic            rsp_valid_q;
   logic            busy_q;
   logic            scan_q;
   logic            load_q;
   logic            csb_q;
   logic            accept;
   logic [REG_WIDTH-1:0] cmd_q_unused;

   assign accept = bus.cmd_valid && cmd_ready_q;

   // gpio_in is the command shifter MSB; it is all-zero outside SHIFT_IN
   scan_shifter #(.REG_WIDTH(REG_WIDTH)) u_cmd (
      .clk     (clk),
      .rst_n   (resetn),
      .load_i  (accept),
      .shift_i (state_q == SHIFT_IN),
      .d_i     (bus.cmd_data),
      .sin_i   (1'b0),
      .q_o     (cmd_q_unused),
      .sout_o  (gpio_in)
   );

`ifdef GPIO_SCAN_READBACK_EN
   logic cap_sout_unused;

   scan_shifter #(.REG_WIDTH(REG_WIDTH)) u_cap (
      .clk     (clk),
      .rst_n   (resetn),
      .load_i  (accept),
      .shift_i (state_q == SHIFT_OUT),
      .d_i     ({REG_WIDTH{1'b0}}),
      .sin_i   (gpio_out),
      .q_o     (bus.rsp_data),
      .sout_o  (cap_sout_unused)
   );
`else
   logic gpio_out_unused;

   assign gpio_out_unused = gpio_out;
   assign bus.rsp_data    = '0;
`endif

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         cmd_ready_q <= 1'b1;
         rsp_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         scan_q      <= 1'b0;
         load_q      <= 1'b0;
         csb_q       <= 1'b1;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (accept) begin
                  state_q     <= SHIFT_IN;
                  cnt_q       <= '0;
                  cmd_ready_q <= 1'b0;
                  busy_q      <= 1'b1;
                  scan_q      <= 1'b1;
               end
            end
            SHIFT_IN: begin
               if (cnt_q == W_LAST) begin
                  state_q <= ACCESS;
                  cnt_q   <= '0;
                  scan_q  <= 1'b0;
                  csb_q   <= 1'b0;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            ACCESS: begin
               if (cnt_q == A_LAST) begin
                  cnt_q <= '0;
                  csb_q <= 1'b1;
`ifdef GPIO_SCAN_READBACK_EN
                  state_q <= LOAD;
                  load_q  <= 1'b1;
`else
                  state_q     <= RESP;
                  rsp_valid_q <= 1'b1;
`endif
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
`ifdef GPIO_SCAN_READBACK_EN
            LOAD: begin
               state_q <= SHIFT_OUT;
               cnt_q   <= '0;
               load_q  <= 1'b0;
               scan_q  <= 1'b1;
            end
            SHIFT_OUT: begin
               if (cnt_q == W_LAST) begin
                  state_q     <= RESP;
                  cnt_q       <= '0;
                  scan_q      <= 1'b0;
                  rsp_valid_q <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
`endif
            RESP: begin
               if (bus.rsp_ready) begin
                  state_q     <= IDLE;
                  cnt_q       <= '0;
                  rsp_valid_q <= 1'b0;
                  busy_q      <= 1'b0;
                  cmd_ready_q <= 1'b1;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign bus.cmd_ready  = cmd_ready_q;
   assign bus.rsp_valid  = rsp_valid_q;
   assign busy           = busy_q;
   assign gpio_scan      = scan_q;
   assign gpio_sram_load = load_q;
   assign global_csb     = csb_q;

endmodule

// File: tb/tb_gpio_scan_sequencer.sv
// Bench for gpio_scan_sequencer with a behavioural test chip model.
// Follows GPIO_SCAN_READBACK_EN like the design does.
module tb_gpio_scan_sequencer;

   localparam int W = 112;
   localparam int A = 2;
`ifdef GPIO_SCAN_READBACK_EN
   localparam bit RB = 1'b1;
`else
   localparam bit RB = 1'b0;
`endif
   localparam int T_RSP = RB ? (2 * W + A + 2) : (W + A + 1);

   typedef struct {
      logic [W-1:0] cmd;
      logic [31:0]  sw;
      int           hold;
      bit           spam;
      logic [W-1:0] exp;
   } vec_t;

   logic clk;
   logic resetn;
   logic busy;
   logic gpio_scan;
   logic gpio_in;
   logic gpio_sram_load;
   logic global_csb;
   logic gpio_out;

   gpio_scan_sequencer_if #(.REG_WIDTH(W)) bus ();

   gpio_scan_sequencer #(
      .REG_WIDTH     (W),
      .ACCESS_CYCLES (A)
   ) dut (
      .clk            (clk),
      .resetn         (resetn),
      .bus            (bus),
      .busy           (busy),
      .gpio_scan      (gpio_scan),
      .gpio_in        (gpio_in),
      .gpio_sram_load (gpio_sram_load),
      .global_csb     (global_csb),
      .gpio_out       (gpio_out)
   );

   always #5 clk = ~clk;

   // Test chip: scan shifts MSB-first; load captures SRAM data
   logic [W-1:0] chip = '0;
   logic [W-1:0] chip_at_load = '0;
   logic [31:0]  sram_word = 32'h0;

   always @(posedge clk) begin
      if (gpio_scan) begin
         chip <= {chip[W-2:0], gpio_in};
      end else if (gpio_sram_load) begin
         chip_at_load <= chip;
         chip <= {chip[W-1:64], sram_word, sram_word};
      end
   end

   assign gpio_out = chip[W-1];

   int n_tests = 0;
   int n_fail  = 0;
   int n_done  = 0;
   int n_load  = 0;
   int n_both  = 0;

   always @(negedge clk) begin
      if (resetn) begin
         if (gpio_sram_load === 1'b1) n_load++;
         if (gpio_scan === 1'b1 && gpio_sram_load === 1'b1) n_both++;
      end
   end

   task automatic chk(input string nm, input logic [W-1:0] act,
                      input logic [W-1:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   function automatic logic [W-1:0] exp_rsp(input logic [W-1:0] c,
                                            input logic [31:0] s);
      return RB ? {c[W-1:64], s, s} : '0;
   endfunction

   function automatic logic exp_scan(input int k);
      return (k >= 1 && k <= W) ||
             (RB && k >= W + A + 2 && k <= 2 * W + A + 1);
   endfunction

   function automatic logic exp_csb(input int k);
      return !(k >= W + 1 && k <= W + A);
   endfunction

   function automatic logic exp_load(input int k);
      return RB && (k == W + A + 1);
   endfunction

   function automatic logic exp_in(input logic [W-1:0] c, input int k);
      if (k >= 1 && k <= W) return c[W-k];
      return 1'b0;
   endfunction

   task automatic wait_ready(input string nm);
      int g;
      g = 0;
      while (bus.cmd_ready !== 1'b1 && g < 50) begin
         @(negedge clk);
         g++;
      end
      chk({nm, " ready"}, W'(bus.cmd_ready), W'(1));
   endtask

   task automatic run_txn(input vec_t v, input string nm);
      int t_rsp;
      int b_scan, b_in, b_csb, b_load, b_rdy, b_hold;
      logic [W-1:0] d0;
      wait_ready(nm);
      sram_word     = v.sw;
      bus.cmd_valid = 1'b1;
      bus.cmd_data  = v.cmd;
      bus.rsp_ready = 1'b0;
      t_rsp = 0;
      b_scan = 0; b_in = 0; b_csb = 0;
      b_load = 0; b_rdy = 0; b_hold = 0;
      for (int k = 1; k <= T_RSP + 20; k++) begin
         @(negedge clk);
         if (v.spam)
            bus.cmd_data = W'({$urandom, $urandom, $urandom, $urandom});
         else
            bus.cmd_valid = 1'b0;
         if (gpio_scan !== exp_scan(k)) b_scan++;
         if (gpio_in !== exp_in(v.cmd, k)) b_in++;
         if (global_csb !== exp_csb(k)) b_csb++;
         if (gpio_sram_load !== exp_load(k)) b_load++;
         if (bus.cmd_ready !== 1'b0 || busy !== 1'b1) b_rdy++;
         if (bus.rsp_valid === 1'b1) begin
            t_rsp = k;
            break;
         end
      end
      chk({nm, " rsp time"}, W'(t_rsp), W'(T_RSP));
      chk({nm, " scan sched"}, W'(b_scan), W'(0));
      chk({nm, " gpio_in sched"}, W'(b_in), W'(0));
      chk({nm, " csb sched"}, W'(b_csb), W'(0));
      chk({nm, " load sched"}, W'(b_load), W'(0));
      chk({nm, " busy/ready"}, W'(b_rdy), W'(0));
      d0 = bus.rsp_data;
      for (int h = 0; h < v.hold; h++) begin
         @(negedge clk);
         if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== d0 ||
             bus.cmd_ready !== 1'b0)
            b_hold++;
      end
      chk({nm, " hold"}, W'(b_hold), W'(0));
      chk({nm, " rsp data"}, d0, v.exp);
      chk({nm, " chip at load"}, chip_at_load, RB ? v.cmd : '0);
      chk({nm, " chip at rsp"}, chip, RB ? '0 : v.cmd);
      bus.rsp_ready = 1'b1;
      bus.cmd_valid = 1'b0;
      @(negedge clk);
      bus.rsp_ready = 1'b0;
      chk({nm, " after hs"},
          W'({bus.rsp_valid, bus.cmd_ready, busy}), W'(3'b010));
      n_done++;
   endtask

   vec_t vecs[4];
   vec_t rv;

   initial begin
      clk = 1'b0;
      resetn = 1'b0;
      bus.cmd_valid = 1'b0;
      bus.cmd_data  = '0;
      bus.rsp_ready = 1'b0;

      vecs[0].cmd = {1'b1, 110'b0, 1'b1};
      vecs[0].sw = 32'hDEADBEEF; vecs[0].hold = 0; vecs[0].spam = 0;
      vecs[1].cmd = '1;
      vecs[1].sw = 32'hDEADBEEF; vecs[1].hold = 10; vecs[1].spam = 1;
      vecs[2].cmd = {56{2'b01}};
      vecs[2].sw = 32'h12345678; vecs[2].hold = 1; vecs[2].spam = 0;
      vecs[3].cmd = '0;
      vecs[3].sw = 32'hFFFFFFFF; vecs[3].hold = 0; vecs[3].spam = 0;
      for (int i = 0; i < 4; i++)
         vecs[i].exp = exp_rsp(vecs[i].cmd, vecs[i].sw);

      repeat (3) @(negedge clk);
      chk("rst cmd_ready", W'(bus.cmd_ready), W'(1));
      chk("rst rsp_valid", W'(bus.rsp_valid), W'(0));
      chk("rst rsp_data", bus.rsp_data, '0);
      chk("rst busy", W'(busy), W'(0));
      chk("rst gpio_scan", W'(gpio_scan), W'(0));
      chk("rst gpio_in", W'(gpio_in), W'(0));
      chk("rst sram_load", W'(gpio_sram_load), W'(0));
      chk("rst global_csb", W'(global_csb), W'(1));
      resetn = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 4; i++)
         run_txn(vecs[i], $sformatf("vec%0d", i));

      wait_ready("midrst");
      bus.cmd_valid = 1'b1;
      bus.cmd_data  = {28{4'hA}};
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      repeat (49) @(negedge clk);
      chk("midrst scan before", W'(gpio_scan), W'(1));
      resetn = 1'b0;
      #1;
      chk("midrst scan", W'(gpio_scan), W'(0));
      chk("midrst busy", W'(busy), W'(0));
      chk("midrst ready", W'(bus.cmd_ready), W'(1));
      chk("midrst csb", W'(global_csb), W'(1));
      @(negedge clk);
      resetn = 1'b1;
      @(negedge clk);
      run_txn(vecs[2], "post-rst");

      for (int i = 0; i < 4; i++) begin
         rv.cmd  = W'({$urandom, $urandom, $urandom, $urandom});
         rv.sw   = $urandom;
         rv.hold = $urandom_range(0, 4);
         rv.spam = 1'($urandom_range(0, 1));
         rv.exp  = exp_rsp(rv.cmd, rv.sw);
         run_txn(rv, $sformatf("rnd%0d", i));
      end

      chk("scan with load", W'(n_both), W'(0));
      chk("load pulses", W'(n_load), W'(RB ? n_done : 0));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
